cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 4: per-requester result valid; 0=int, 1=mult, 2=div, 3=ldst.
REQ-004 SHALL have port req_data, input, 128: packed 32-bit results, requester i at bits [32i+31:32i].
REQ-005 SHALL have port req_tag, input, 24: packed 6-bit ROB tags, requester i at bits [6i+5:6i].
REQ-006 SHALL have ports req_branch and req_branch_taken, input, 4 each: per-requester branch flag and taken flag.
REQ-007 SHALL have port req_ack, output, 4: one-hot grant, combinational, same cycle.
REQ-008 SHALL have port flush, input, 1: mispredict kill of the broadcast in progress.
REQ-009 SHALL have ports cdb_data (32), cdb_tag (6), cdb_valid (1), cdb_branch (1) and cdb_branch_taken (1), all registered outputs: the common data bus broadcast.

Function
REQ-010 SHALL assert at most one req_ack bit per cycle, and only for a requester whose req_valid=1.
REQ-011 SHALL drive req_ack=0 in any cycle with flush=1 or rst=1.
REQ-012 Requesters SHALL hold valid and payload stable until acked; the arbiter relies on this and does not sample unacked payloads.
REQ-013 SHALL register the granted payload onto the cdb_* outputs at the next rising edge, giving a 1-cycle latency from ack to cdb_valid=1.
REQ-014 SHALL assert cdb_valid for exactly one cycle per grant, so back-to-back grants produce back-to-back broadcasts at full throughput of 1 per cycle.
REQ-015 SHALL drive cdb_data, cdb_tag, cdb_branch and cdb_branch_taken to 0 in every cycle where cdb_valid=0.
REQ-016 Round-robin mode SHALL keep a 2-bit priority pointer ptr and grant the first valid requester searching ptr, ptr+1, ... mod 4.
REQ-017 After a grant to requester i, ptr SHALL become (i+1) mod 4; 3 wraps to 0.
REQ-018 ptr SHALL hold its value in cycles with no grant, including idle and flush cycles.
REQ-019 flush=1 in cycle N SHALL force cdb_valid=0 at edge N+1, cancelling any registered broadcast.
REQ-020 A flush coincident with requests SHALL leave those requests pending, to be acked after flush deasserts.
REQ-021 req_valid dropping without an ack SHALL be tolerated: no grant, no state change.

Reset
REQ-022 On rst assertion, cdb_* outputs SHALL go to 0 and ptr to 0 immediately, without waiting for clk.
REQ-023 Reset mid-broadcast SHALL discard the broadcast, with no cdb_valid pulse after rst deasserts.
REQ-024 The first grant after reset SHALL follow ptr=0, or fixed priority when REQ-025 applies.

Configuration
REQ-025 With macro CDB_ARB_FIXED_PRIO_EN defined, SHALL use fixed priority mult(1) > int(0) > div(2) > ldst(3); ptr is not implemented.
REQ-026 Without CDB_ARB_FIXED_PRIO_EN, SHALL use the round-robin behaviour of REQ-016 to REQ-018.

Verification
REQ-027 Reset, then req_valid=0001, data0=0x0000_1234, tag0=5 -> req_ack=0001 same cycle; next cycle cdb_valid=1, cdb_data=0x1234, cdb_tag=5; one cycle later cdb_valid=0 and cdb_data=0.
REQ-028 Round-robin, req_valid=1111 held for 5 cycles -> acks in order 0001, 0010, 0100, 1000, 0001; continuous cdb_valid=1.
REQ-029 ptr=3 with req_valid=1001 -> ack 1000; then ptr=0, so the next grant is 0001 (wrap).
REQ-030 Grant to req 2 in cycle N and flush=1 in cycle N -> no ack in N, cdb_valid=0 at N+1; req 2 acked at N+1 once flush=0.
REQ-031 rst asserted asynchronously while cdb_valid=1 -> cdb_valid=0 without a clk edge; after release req_valid=1111 -> ack 0001.
REQ-032 CDB_ARB_FIXED_PRIO_EN defined with req_valid=1111 for 3 cycles -> ack 0010 every cycle; branch request tag 9 with taken=1 -> cdb_branch=1, cdb_branch_taken=1.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Common data bus arbiter granting one of four result producers
//            per cycle and registering the winner onto the CDB. Round-robin by
//            default; define CDB_ARB_FIXED_PRIO_EN for fixed priority
//            mult > int > div > ldst.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  input  logic [127:0] req_data,
  input  logic [23:0]  req_tag,
  input  logic [3:0]   req_branch,
  input  logic [3:0]   req_branch_taken,
  output logic [3:0]   req_ack,
  input  logic         flush,
  output logic [31:0]  cdb_data,
  output logic [5:0]   cdb_tag,
  output logic         cdb_valid,
  output logic         cdb_branch,
  output logic         cdb_branch_taken
);

  logic        w_gnt;
  logic [1:0]  w_sel;
  logic [3:0]  w_ack;

  logic [31:0] r_cdb_data;
  logic [5:0]  r_cdb_tag;
  logic        r_cdb_valid;
  logic        r_cdb_branch;
  logic        r_cdb_branch_taken;

`ifdef CDB_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt = 1'b0;
    w_sel = 2'd0;
    if (req_valid[1]) begin
      w_gnt = 1'b1;
      w_sel = 2'd1;
    end else if (req_valid[0]) begin
      w_gnt = 1'b1;
      w_sel = 2'd0;
    end else if (req_valid[2]) begin
      w_gnt = 1'b1;
      w_sel = 2'd2;
    end else if (req_valid[3]) begin
      w_gnt = 1'b1;
      w_sel = 2'd3;
    end
  end
`else
  logic [1:0] r_ptr;
  logic [1:0] w_idx;

  // Search starts at the pointer and wraps modulo 4.
  always_comb begin
    w_gnt = 1'b0;
    w_sel = 2'd0;
    w_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + k[1:0];
      if (!w_gnt && req_valid[w_idx]) begin
        w_gnt = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 2'd0;
    end else if (w_gnt && !flush) begin
      r_ptr <= w_sel + 2'd1;
    end
  end
`endif

  // No grant is issued while flushing or in reset; requests stay pending.
  always_comb begin
    w_ack = 4'b0000;
    if (w_gnt && !flush && !rst) begin
      w_ack[w_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb_valid        <= 1'b0;
      r_cdb_data         <= 32'd0;
      r_cdb_tag          <= 6'd0;
      r_cdb_branch       <= 1'b0;
      r_cdb_branch_taken <= 1'b0;
    end else if (w_gnt && !flush) begin
      r_cdb_valid        <= 1'b1;
      r_cdb_data         <= req_data[32*w_sel +: 32];
      r_cdb_tag          <= req_tag[6*w_sel +: 6];
      r_cdb_branch       <= req_branch[w_sel];
      r_cdb_branch_taken <= req_branch_taken[w_sel];
    end else begin
      r_cdb_valid        <= 1'b0;
      r_cdb_data         <= 32'd0;
      r_cdb_tag          <= 6'd0;
      r_cdb_branch       <= 1'b0;
      r_cdb_branch_taken <= 1'b0;
    end
  end

  assign req_ack          = w_ack;
  assign cdb_valid        = r_cdb_valid;
  assign cdb_data         = r_cdb_data;
  assign cdb_tag          = r_cdb_tag;
  assign cdb_branch       = r_cdb_branch;
  assign cdb_branch_taken = r_cdb_branch_taken;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter with a CDB
//            scoreboard. Honours CDB_ARB_FIXED_PRIO_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [23:0]  req_tag;
  logic [3:0]   req_branch;
  logic [3:0]   req_branch_taken;
  logic [3:0]   req_ack;
  logic         flush;
  logic [31:0]  cdb_data;
  logic [5:0]   cdb_tag;
  logic         cdb_valid;
  logic         cdb_branch;
  logic         cdb_branch_taken;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  tag;
    logic        br;
    logic        tk;
  } bcast_t;

  bcast_t sb_q[$];
  int     n_err;
  int     n_chk;

  cdb_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_tag          (req_tag),
    .req_branch       (req_branch),
    .req_branch_taken (req_branch_taken),
    .req_ack          (req_ack),
    .flush            (flush),
    .cdb_data         (cdb_data),
    .cdb_tag          (cdb_tag),
    .cdb_valid        (cdb_valid),
    .cdb_branch       (cdb_branch),
    .cdb_branch_taken (cdb_branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cdb(input string tag);
    bcast_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_valid"}, {63'd0, cdb_valid}, 64'd1);
      chk({tag, "_payload"}, {24'd0, cdb_data, cdb_tag, cdb_branch, cdb_branch_taken},
          {24'd0, e.data, e.tag, e.br, e.tk});
    end else begin
      chk({tag, "_idle"}, {24'd0, cdb_data, cdb_tag, cdb_branch, cdb_branch_taken, cdb_valid},
          64'd0);
    end
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic cycle(input string tag, input logic [3:0] exp_ack);
    bcast_t e;
    #2;
    chk({tag, "_ack"}, {60'd0, req_ack}, {60'd0, exp_ack});
    for (int i = 0; i < 4; i++) begin
      if (exp_ack[i]) begin
        e.data = req_data[32*i +: 32];
        e.tag  = req_tag[6*i +: 6];
        e.br   = req_branch[i];
        e.tk   = req_branch_taken[i];
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk_cdb(tag);
  endtask

  initial begin
    n_err            = 0;
    n_chk            = 0;
    rst              = 1'b1;
    flush            = 1'b0;
    req_valid        = 4'b1111;
    req_data         = {32'hD00D_0003, 32'hCAFE_0002, 32'hBEEF_0001, 32'h0000_1234};
    req_tag          = {6'd33, 6'd9, 6'd17, 6'd5};
    req_branch       = 4'b1100;
    req_branch_taken = 4'b0100;

    #12;
    chk("rst_ack", {60'd0, req_ack}, 64'd0);
    chk_cdb("rst_cdb");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;

`ifdef CDB_ARB_FIXED_PRIO_EN
    req_tag          = {6'd33, 6'd9, 6'd9, 6'd5};
    req_branch       = 4'b0010;
    req_branch_taken = 4'b0010;
    req_valid = 4'b1111;
    cycle("fp0", 4'b0010);
    cycle("fp1", 4'b0010);
    cycle("fp2", 4'b0010);
    req_valid = 4'b1101;
    cycle("fp_int", 4'b0001);
    req_valid = 4'b1100;
    cycle("fp_div", 4'b0100);
    req_valid = 4'b1000;
    cycle("fp_ldst", 4'b1000);
    flush     = 1'b1;
    req_valid = 4'b0010;
    cycle("fp_flush", 4'b0000);
    flush = 1'b0;
    cycle("fp_after_flush", 4'b0010);
    req_valid = 4'b0000;
    cycle("fp_idle", 4'b0000);
`else
    // Single request, 1-cycle latency, then idle zeros.
    req_valid = 4'b0001;
    cycle("single", 4'b0001);
    req_valid = 4'b0000;
    cycle("single_idle", 4'b0000);

    // Pointer back to 0 via a short asynchronous reset pulse.
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    cycle("rr0", 4'b0001);
    cycle("rr1", 4'b0010);
    cycle("rr2", 4'b0100);
    cycle("rr3", 4'b1000);
    cycle("rr4", 4'b0001);

    // ptr=1: grant req 2 moves ptr to 3, then wrap from 3 to 0.
    req_valid = 4'b0100;
    cycle("to_ptr3", 4'b0100);
    req_valid = 4'b1001;
    cycle("wrap3", 4'b1000);
    cycle("wrap0", 4'b0001);

    // ptr=1: flush blocks a req-2 grant; granted once flush drops; ptr held.
    req_valid = 4'b0100;
    flush     = 1'b1;
    cycle("flush", 4'b0000);
    flush = 1'b0;
    cycle("post_flush", 4'b0100);
    req_valid = 4'b1111;
    cycle("ptr_after_flush", 4'b1000);

    // Request withdrawn without ack, then idle: ptr stays 0.
    req_valid = 4'b0000;
    cycle("withdraw", 4'b0000);
    req_valid = 4'b1111;
    cycle("ptr_held_idle", 4'b0001);

    // ptr=1: branch broadcast from req 2, then async reset mid-broadcast.
    req_valid = 4'b0100;
    cycle("branch", 4'b0100);
    #1;
    rst = 1'b1;
    #1;
    chk_cdb("async_rst");
    req_valid = 4'b1111;
    chk("rst_ack_hold", {60'd0, req_ack}, 64'd0);
    @(posedge clk);
    #2;
    rst       = 1'b0;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    chk_cdb("no_pulse_after_rst");
    req_valid = 4'b1111;
    cycle("first_after_rst", 4'b0001);
    req_valid = 4'b0000;
    cycle("final_idle", 4'b0000);
`endif

    chk("sb_empty", {32'd0, sb_q.size()}, 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
